// File: rtl/exc_pipe_if.sv
// Request/acknowledge channel between the M stage of the exception pipeline and cp0.
// The pipeline drives the request side through the master modport.
interface exc_pipe_if #(
   parameter int PC_W   = 32,
   parameter int CODE_W = 5
);
   logic              M_Exc_Req;
   logic [CODE_W-1:0] M_Exc_Code;
   logic [PC_W-1:0]   M_Exc_PC;
   logic              M_Exc_Ack;

   modport master (output M_Exc_Req, output M_Exc_Code, output M_Exc_PC, input M_Exc_Ack);
   modport slave  (input M_Exc_Req, input M_Exc_Code, input M_Exc_PC, output M_Exc_Ack);
endinterface

// File: rtl/exc_pipe.sv
// Exception-tracking pipeline: carries the first-detected exception code and restart PC
// from IF to M and presents the precise exception to cp0 over a req/ack handshake.
module exc_pipe #(
   parameter int PC_W   = 32,
   parameter int CODE_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [PC_W-1:0]   IF_PC,
   input  logic              IF_Valid,
   input  logic              IF_Exc_Detect,
   input  logic [CODE_W-1:0] IF_Exc_Code,
   input  logic              ID_Exc_Detect,
   input  logic [CODE_W-1:0] ID_Exc_Code,
   input  logic              EX_Exc_Detect,
   input  logic [CODE_W-1:0] EX_Exc_Code,
   input  logic              M_Exc_Detect,
   input  logic [CODE_W-1:0] M_Exc_Code,
   input  logic              IF_Stall,
   input  logic              ID_Stall,
   input  logic              EX_Stall,
   input  logic              M_Stall,
   input  logic              IF_Exception_Flush,
   input  logic              ID_Exception_Flush,
   input  logic              EX_Exception_Flush,
   input  logic              M_Exception_Flush,
   output logic              ID_Exc_Pending,
   output logic              EX_Exc_Pending,
   output logic              M_Exc_Pending,
   exc_pipe_if.master        cp0
);

   typedef struct packed {
      logic              valid;
      logic              pending;
      logic [CODE_W-1:0] code;
      logic [PC_W-1:0]   pc;
   } stage_t;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] REQ  = 1'b1;

   stage_t            id_q, ex_q, m_q, m_next;
   stage_t            if_view, id_view, ex_view;
   logic              m_pend;
   logic [CODE_W-1:0] m_code;
   logic [0:0]        state;
   logic [CODE_W-1:0] req_code;
   logic [PC_W-1:0]   req_pc;

   // A stored exception always wins over a detect arriving in a later stage.
   function automatic stage_t merge(input stage_t r, input logic det, input logic [CODE_W-1:0] code);
      stage_t v;
      v         = r;
      v.pending = r.valid & (r.pending | det);
      v.code    = r.pending ? r.code : code;
      return v;
   endfunction

   function automatic stage_t advance(input stage_t cur, input stage_t up, input logic flush,
                                      input logic stall, input logic up_hold);
      stage_t n;
      n = cur;
      if (flush || (!stall && up_hold)) begin
         n.valid   = 1'b0;
         n.pending = 1'b0;
      end else if (!stall) begin
         n = up;
      end
      return n;
   endfunction

   always_comb begin
      if_view.valid   = IF_Valid;
      if_view.pending = IF_Valid & IF_Exc_Detect;
      if_view.code    = IF_Exc_Code;
      if_view.pc      = IF_PC;
   end

   assign id_view = merge(id_q, ID_Exc_Detect, ID_Exc_Code);
   assign ex_view = merge(ex_q, EX_Exc_Detect, EX_Exc_Code);
   assign m_pend  = m_q.valid & (m_q.pending | M_Exc_Detect);
   assign m_code  = m_q.pending ? m_q.code : M_Exc_Code;

   assign ID_Exc_Pending = id_view.pending;
   assign EX_Exc_Pending = ex_view.pending;
   assign M_Exc_Pending  = m_pend;

   // While a request is outstanding the faulting instruction is pinned in M; ack retires it.
   always_comb begin
      m_next = advance(m_q, ex_view, M_Exception_Flush, M_Stall, EX_Stall | EX_Exception_Flush);
      if (state == REQ) begin
         m_next = m_q;
         if (cp0.M_Exc_Ack) begin
            m_next.valid   = 1'b0;
            m_next.pending = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         id_q <= '0;
         ex_q <= '0;
         m_q  <= '0;
      end else begin
         id_q <= advance(id_q, if_view, ID_Exception_Flush, ID_Stall, IF_Stall | IF_Exception_Flush);
         ex_q <= advance(ex_q, id_view, EX_Exception_Flush, EX_Stall, ID_Stall | ID_Exception_Flush);
         m_q  <= m_next;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         req_code <= '0;
         req_pc   <= '0;
      end else if (state == IDLE) begin
         if (m_pend) begin
            state    <= REQ;
            req_code <= m_code;
            req_pc   <= m_q.pc;
         end
      end else if (cp0.M_Exc_Ack) begin
         state <= IDLE;
      end
   end

   assign cp0.M_Exc_Req  = (state == REQ);
   assign cp0.M_Exc_Code = req_code;
   assign cp0.M_Exc_PC   = req_pc;

endmodule
